// File: rtl/riscv_pkg.sv
// Shared encodings for the memory-access path: RV32I load/store funct3 values,
// fault codes and the mem_unit state encoding.
package riscv_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef enum logic [1:0] {
        FaultNone    = 2'b00,
        FaultAlign   = 2'b01,
        FaultTimeout = 2'b10
    } fault_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StDone = 2'd2
    } mem_state_e;

endpackage

// File: rtl/load_store_align.sv
// Combinational byte-lane logic: store enables and replication, load lane
// extraction with sign/zero extension, and alignment/size legality.
module load_store_align
    import riscv_pkg::*;
(
    input  logic        i_fetch,
    input  logic        i_store,
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_mem_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_load_data,
    output logic        o_illegal
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_mem_rdata[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_mem_rdata[{i_addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        o_be        = 4'b1111;
        o_wdata     = i_wdata;
        o_load_data = i_mem_rdata;
        o_illegal   = 1'b0;
        if (i_fetch) begin
            o_illegal = (i_addr_lo != 2'b00);
        end else if (i_store) begin
            case (i_funct3)
                SB: begin
                    o_be    = 4'b0001 << i_addr_lo;
                    o_wdata = {4{i_wdata[7:0]}};
                end
                SH: begin
                    o_be      = 4'b0011 << i_addr_lo;
                    o_wdata   = {2{i_wdata[15:0]}};
                    o_illegal = i_addr_lo[0];
                end
                SW:      o_illegal = (i_addr_lo != 2'b00);
                default: o_illegal = 1'b1;
            endcase
        end else begin
            case (i_funct3)
                LB:  o_load_data = {{24{w_byte[7]}}, w_byte};
                LBU: o_load_data = {24'h000000, w_byte};
                LH: begin
                    o_load_data = {{16{w_half[15]}}, w_half};
                    o_illegal   = i_addr_lo[0];
                end
                LHU: begin
                    o_load_data = {16'h0000, w_half};
                    o_illegal   = i_addr_lo[0];
                end
                LW:      o_illegal = (i_addr_lo != 2'b00);
                default: o_illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/mem_unit.sv
// Multicycle memory-access unit: fetches into ir, byte/half/word loads and
// stores over a variable-latency word bus, with alignment checks and a watchdog.
module mem_unit
    import riscv_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        addr_src,
    input  logic        we,
    input  logic        instr_we,
    input  logic [2:0]  funct3,
    input  logic [31:0] pc,
    input  logic [31:0] alu_result,
    input  logic [31:0] wdata,
    output logic [31:0] ir,
    output logic [31:0] old_pc,
    output logic [31:0] rdata,
    output logic        done,
    output logic        busy,
    output logic [1:0]  fault,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

    mem_state_e  r_state;
    logic        r_fetch;
    logic        r_store;
    logic        r_instr_we;
    logic [2:0]  r_funct3;
    logic [1:0]  r_addr_lo;
    logic [31:0] r_pc;
    logic [7:0]  r_cnt;

    logic        w_idle;
    logic [31:0] w_addr;
    logic        w_fetch;
    logic        w_store;
    logic [2:0]  w_funct3;
    logic [1:0]  w_addr_lo;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_load_data;
    logic        w_illegal;

    // One aligner serves both phases: live inputs in IDLE, latched access in REQ.
    assign w_idle    = (r_state == StIdle);
    assign w_addr    = addr_src ? alu_result : pc;
    assign w_fetch   = w_idle ? ~addr_src : r_fetch;
    assign w_store   = w_idle ? (addr_src & we) : r_store;
    assign w_funct3  = w_idle ? funct3 : r_funct3;
    assign w_addr_lo = w_idle ? w_addr[1:0] : r_addr_lo;

    load_store_align u_align (
        .i_fetch     (w_fetch),
        .i_store     (w_store),
        .i_funct3    (w_funct3),
        .i_addr_lo   (w_addr_lo),
        .i_wdata     (wdata),
        .i_mem_rdata (mem_rdata),
        .o_be        (w_be),
        .o_wdata     (w_wdata),
        .o_load_data (w_load_data),
        .o_illegal   (w_illegal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= StIdle;
            r_fetch    <= 1'b0;
            r_store    <= 1'b0;
            r_instr_we <= 1'b0;
            r_funct3   <= 3'b000;
            r_addr_lo  <= 2'b00;
            r_pc       <= 32'h0;
            r_cnt      <= 8'h00;
            ir         <= 32'h0;
            old_pc     <= 32'h0;
            rdata      <= 32'h0;
            done       <= 1'b0;
            busy       <= 1'b0;
            fault      <= FaultNone;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'h0;
            mem_be     <= 4'b0000;
            mem_wdata  <= 32'h0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (start) begin
                        r_fetch    <= ~addr_src;
                        r_store    <= addr_src & we;
                        r_instr_we <= instr_we;
                        r_funct3   <= funct3;
                        r_addr_lo  <= w_addr[1:0];
                        r_pc       <= pc;
                        r_cnt      <= 8'h00;
                        busy       <= 1'b1;
                        if (w_illegal) begin
                            r_state <= StDone;
                            done    <= 1'b1;
                            fault   <= FaultAlign;
                        end else begin
                            r_state   <= StReq;
                            mem_req   <= 1'b1;
                            mem_we    <= addr_src & we;
                            mem_addr  <= {w_addr[31:2], 2'b00};
                            mem_be    <= w_be;
                            mem_wdata <= w_wdata;
                        end
                    end
                end
                StReq: begin
                    if (mem_ack) begin
                        r_state <= StDone;
                        done    <= 1'b1;
                        fault   <= FaultNone;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        if (!r_fetch && !r_store) begin
                            rdata <= w_load_data;
                        end
                        if (r_fetch && r_instr_we) begin
                            ir     <= mem_rdata;
                            old_pc <= r_pc;
                        end
                    end else if (r_cnt == CntLast) begin
                        r_state <= StDone;
                        done    <= 1'b1;
                        fault   <= FaultTimeout;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    fault   <= FaultNone;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_unit.sv
// Scoreboard bench for mem_unit: byte-array reference model, word-wide bus slave
// with random wait states and stray acks, and a done-driven result monitor.
module tb_mem_unit;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start, addr_src, we, instr_we;
    logic [2:0]  funct3;
    logic [31:0] pc, alu_result, wdata;
    logic [31:0] ir, old_pc, rdata;
    logic        done, busy;
    logic [1:0]  fault;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_ack = 1'b0;

    mem_unit #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .addr_src   (addr_src),
        .we         (we),
        .instr_we   (instr_we),
        .funct3     (funct3),
        .pc         (pc),
        .alu_result (alu_result),
        .wdata      (wdata),
        .ir         (ir),
        .old_pc     (old_pc),
        .rdata      (rdata),
        .done       (done),
        .busy       (busy),
        .fault      (fault),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  fault;
        logic [31:0] rdata;
        logic [31:0] ir;
        logic [31:0] old_pc;
        int          lat;
        int          c0;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        chk_wd;
        int          k;
    } req_t;

    exp_t        exp_q[$];
    req_t        req_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    logic [7:0]  rm[256];
    logic [31:0] sl_mem[64];
    logic [31:0] ref_ir = 32'h0, ref_old_pc = 32'h0, ref_rdata = 32'h0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse consumes one expected result.
    exp_t mon_e;
    always @(negedge clk) begin
        if (!rst && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL spurious_done: got done=1, expected done=0 (cycle %0d)", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("fault", {30'h0, fault}, {30'h0, mon_e.fault});
                chk("rdata", rdata, mon_e.rdata);
                chk("ir", ir, mon_e.ir);
                chk("old_pc", old_pc, mon_e.old_pc);
                chk("latency", 32'(cyc - mon_e.c0), 32'(mon_e.lat));
                chk("busy_at_done", {31'h0, busy}, 32'h1);
            end
        end
    end

    // Bus slave: word memory honouring byte enables; random stray acks when idle.
    logic serving = 1'b0;
    int   wait_left = 0;
    int   sl_idx;
    req_t sl_r;
    always @(negedge clk) begin
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        if (mem_req !== 1'b1) begin
            serving = 1'b0;
            if ($urandom_range(0, 1) == 1) mem_ack = 1'b1;
        end else begin
            if (!serving) begin
                serving = 1'b1;
                if (req_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_mem_req: got mem_req=1, expected 0 (cycle %0d)", cyc);
                    wait_left = 1000;
                end else begin
                    sl_r = req_q.pop_front();
                    chk("mem_addr", mem_addr, sl_r.addr);
                    chk("mem_we", {31'h0, mem_we}, {31'h0, sl_r.we});
                    chk("mem_be", {28'h0, mem_be}, {28'h0, sl_r.be});
                    if (sl_r.chk_wd) chk("mem_wdata", mem_wdata, sl_r.wdata);
                    wait_left = sl_r.k;
                end
            end
            if (wait_left == 0) begin
                mem_ack   = 1'b1;
                sl_idx    = int'(mem_addr[7:2]);
                mem_rdata = sl_mem[sl_idx];
                for (int j = 0; j < 4; j++) begin
                    if (mem_we && mem_be[j]) sl_mem[sl_idx][8*j +: 8] = mem_wdata[8*j +: 8];
                end
                wait_left = -1;
            end else begin
                wait_left--;
            end
        end
    end

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        logic [31:0] w;
        logic [7:0]  b;
        for (int i = 0; i < 4; i++) begin
            b = {a[7:2], 2'b00} + 8'(i);
            w[8*i +: 8] = rm[b];
        end
        return w;
    endfunction

    task automatic set_word(input logic [31:0] a, input logic [31:0] w);
        logic [7:0] b;
        sl_mem[int'(a[7:2])] = w;
        for (int i = 0; i < 4; i++) begin
            b = {a[7:2], 2'b00} + 8'(i);
            rm[b] = w[8*i +: 8];
        end
    endtask

    // Reference model: decides legality and outcome, queues expectations, drives start.
    task automatic issue(input logic src, input logic w, input logic iwe, input logic [2:0] f3,
                         input logic [31:0] p, input logic [31:0] alu, input logic [31:0] wd,
                         input int k);
        logic [31:0] a;
        int          n;
        logic        legal;
        logic [63:0] v;
        logic [7:0]  b;
        exp_t        e;
        req_t        r;
        a = src ? alu : p;
        if (!src) begin
            n = 4;
            legal = (a[1:0] == 2'b00);
        end else begin
            n = 1 << f3[1:0];
            if (w) legal = (f3 <= 3'd2);
            else   legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
            legal = legal && ((a % n) == 0);
        end
        e.c0 = cyc;
        if (!legal) begin
            e.fault = 2'b01;
            e.lat   = 1;
        end else if (k >= int'(TO)) begin
            e.fault = 2'b10;
            e.lat   = int'(TO) + 1;
        end else begin
            e.fault = 2'b00;
            e.lat   = 2 + k;
            if (!src) begin
                if (iwe) begin
                    ref_ir     = ref_word(a);
                    ref_old_pc = p;
                end
            end else if (w) begin
                for (int i = 0; i < n; i++) begin
                    b = a[7:0] + 8'(i);
                    rm[b] = wd[8*i +: 8];
                end
            end else begin
                v = 64'h0;
                for (int i = 0; i < n; i++) begin
                    b = a[7:0] + 8'(i);
                    v = v | (64'(rm[b]) << (8 * i));
                end
                if (!f3[2] && n < 4 && v[8*n-1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
                ref_rdata = v[31:0];
            end
        end
        e.rdata  = ref_rdata;
        e.ir     = ref_ir;
        e.old_pc = ref_old_pc;
        exp_q.push_back(e);
        if (legal) begin
            r.addr   = {a[31:2], 2'b00};
            r.we     = src & w;
            r.be     = (src && w) ? 4'(((1 << n) - 1) << a[1:0]) : 4'hF;
            r.chk_wd = src & w;
            for (int j = 0; j < 4; j++) r.wdata[8*j +: 8] = wd[8*(j % n) +: 8];
            r.k = k;
            req_q.push_back(r);
        end
        start      = 1'b1;
        addr_src   = src;
        we         = w;
        instr_we   = iwe;
        funct3     = f3;
        pc         = p;
        alu_result = alu;
        wdata      = wd;
    endtask

    task automatic junk();
        start      = 1'($urandom_range(0, 1));
        addr_src   = 1'($urandom);
        we         = 1'($urandom);
        instr_we   = 1'($urandom);
        funct3     = 3'($urandom);
        pc         = $urandom;
        alu_result = $urandom;
        wdata      = $urandom;
    endtask

    // Issue in an IDLE cycle, pulse ignored starts while busy, return in the DONE cycle.
    task automatic access(input logic src, input logic w, input logic iwe, input logic [2:0] f3,
                          input logic [31:0] p, input logic [31:0] alu, input logic [31:0] wd,
                          input int k);
        bit seen = 1'b0;
        @(negedge clk);
        #2;
        issue(src, w, iwe, f3, p, alu, wd, k);
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            #2;
            if (exp_q.size() == 0) begin
                seen  = 1'b1;
                start = 1'b0;
                break;
            end
            junk();
        end
        if (!seen) begin
            n_vec++;
            n_err++;
            $display("FAIL done_wait: got no done in 20 cycles, expected done (cycle %0d)", cyc);
            exp_q.delete();
            req_q.delete();
            start = 1'b0;
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_ir"}, ir, 32'h0);
        chk({tag, "_old_pc"}, old_pc, 32'h0);
        chk({tag, "_rdata"}, rdata, 32'h0);
        chk({tag, "_mem_addr"}, mem_addr, 32'h0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
        chk({tag, "_mem_be"}, {28'h0, mem_be}, 32'h0);
        chk({tag, "_mem_req"}, {31'h0, mem_req}, 32'h0);
        chk({tag, "_mem_we"}, {31'h0, mem_we}, 32'h0);
        chk({tag, "_done"}, {31'h0, done}, 32'h0);
        chk({tag, "_busy"}, {31'h0, busy}, 32'h0);
        chk({tag, "_fault"}, {30'h0, fault}, 32'h0);
    endtask

    logic [31:0] ra;
    initial begin
        start = 1'b0; addr_src = 1'b0; we = 1'b0; instr_we = 1'b0; funct3 = 3'b000;
        pc = 32'h0; alu_result = 32'h0; wdata = 32'h0;
        for (int i = 0; i < 64; i++) set_word(32'(i * 4), $urandom);
        repeat (2) @(negedge clk);
        check_reset("reset");
        #2 rst = 1'b0;

        set_word(32'h10, 32'h00500093);
        access(1'b0, 1'b0, 1'b1, 3'b111, 32'h10, $urandom, $urandom, 0);
        set_word(32'h100, 32'h80FF0000);
        access(1'b1, 1'b0, 1'b0, 3'b000, $urandom, 32'h103, $urandom, 1);
        access(1'b1, 1'b0, 1'b0, 3'b100, $urandom, 32'h103, $urandom, 2);
        access(1'b1, 1'b1, 1'b1, 3'b001, $urandom, 32'h102, 32'h1234ABCD, 1);
        access(1'b1, 1'b0, 1'b0, 3'b001, $urandom, 32'h100, $urandom, 0);
        access(1'b1, 1'b0, 1'b0, 3'b010, $urandom, 32'h201, $urandom, 0);
        access(1'b0, 1'b0, 1'b1, 3'b010, 32'h6, $urandom, $urandom, 0);
        access(1'b1, 1'b0, 1'b0, 3'b010, $urandom, 32'h20, $urandom, 99);
        access(1'b1, 1'b0, 1'b0, 3'b010, $urandom, 32'h20, $urandom, 3);
        access(1'b0, 1'b0, 1'b0, 3'b000, 32'h24, $urandom, $urandom, 1);

        // Reset during the second wait cycle of a store that would never be acked.
        @(negedge clk);
        #2 issue(1'b1, 1'b1, 1'b0, 3'b010, $urandom, 32'h40, 32'hDEADBEEF, 200);
        exp_q.delete();
        @(negedge clk);
        #2 start = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset("rst_mid");
        req_q.delete();
        exp_q.delete();
        ref_ir = 32'h0; ref_old_pc = 32'h0; ref_rdata = 32'h0;
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("after_rst");
        access(1'b1, 1'b0, 1'b0, 3'b010, $urandom, 32'h40, $urandom, 1);

        for (int it = 0; it < 300; it++) begin
            ra = $urandom;
            if ($urandom_range(0, 1) == 1) ra[1:0] = 2'b00;
            access(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom_range(0, 3) != 0),
                   3'($urandom), ra, ra, $urandom, int'($urandom_range(0, 5)));
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_unit.md
# mem_unit

Multicycle memory-access unit between the control FSM/datapath and a single-port, word-wide, variable-latency memory. It serves instruction fetches into the instruction register and data loads and stores (byte, halfword and word), and signals completion back to the control FSM. It owns byte-lane alignment, sign/zero extension, alignment checks and a bus-timeout watchdog.

## Interface
Parameters:
- TIMEOUT, 255: maximum number of cycles in REQ without mem_ack before a timeout fault. Legal range is 1..255.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  access request from the control FSM; sampled only in IDLE
- addr_src  in  1  0 selects pc (fetch), 1 selects alu_result (data)
- we  in  1  1 = store, 0 = load or fetch; ignored when addr_src=0
- instr_we  in  1  capture the fetched word into ir; used only when addr_src=0
- funct3  in  3  data access size and sign (RV32I load/store encoding)
- pc  in  32  fetch address
- alu_result  in  32  data address
- wdata  in  32  store data (rs2)
- ir  out  32  instruction register
- old_pc  out  32  pc latched together with ir
- rdata  out  32  load data register, extended
- done  out  1  one-cycle completion pulse
- busy  out  1  high whenever not in IDLE
- fault  out  2  00 none, 01 misaligned or illegal size, 10 timeout; valid while done=1
- mem_req  out  1  memory request, held until ack
- mem_we  out  1  memory write enable
- mem_addr  out  32  word address; bits [1:0] are always 0
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated store data
- mem_rdata  in  32  memory read data
- mem_ack  in  1  memory completion; sampled only in REQ

## Operation
- FSM states: IDLE, REQ, DONE.
- IDLE + start:
  - Latch address (pc or alu_result per addr_src), we, instr_we, funct3 and pc.
  - Legal access: go to REQ.
  - Illegal access: go to DONE with fault=01 and no memory request.
- Illegal accesses:
  - Fetch with addr[1:0]≠0.
  - Halfword with addr[0]=1.
  - Word with addr[1:0]≠0.
  - Data funct3 outside {000, 001, 010, 100, 101} for loads.
  - Data funct3 outside {000, 001, 010} for stores.
- A fetch is always a word access; funct3 is ignored.
- REQ:
  - mem_req=1 and the address, we, be and wdata registers are held stable.
  - The wait counter increments each cycle.
  - On mem_ack, go to DONE with fault=00. Load: rdata <= extracted lane. Fetch with instr_we: ir <= mem_rdata and old_pc <= latched pc.
  - If the counter reaches TIMEOUT with no ack, drop mem_req and go to DONE with fault=10. No register updates.
- DONE: done=1 for exactly one cycle, then IDLE. fault is cleared on leaving DONE.
- Store byte enables:
  - sb: be = 0001 << addr[1:0], mem_wdata = {4{wdata[7:0]}}.
  - sh: be = 0011 << addr[1:0], mem_wdata = {2{wdata[15:0]}}.
  - sw: be = 1111, mem_wdata = wdata.
- Load extract: lane selected by addr[1:0]. lb/lh sign-extend, lbu/lhu zero-extend, lw passes through.
- Loads and fetches drive mem_be=1111 and mem_we=0.
- start while busy is ignored, not queued. mem_ack outside REQ is ignored.
- ir, old_pc and rdata hold their values until their next capture. Stores, faults and fetches with instr_we=0 leave them unchanged.

## Timing
- Reset values: state IDLE; ir, old_pc, rdata, mem_addr, mem_wdata = 0; mem_be=0000; mem_req, mem_we, done, busy = 0; fault=00.
- rst mid-access drops mem_req asynchronously. A pending ack is then ignored.
- All outputs are registered.
- Legal access timeline:
  - start sampled at edge 0.
  - mem_req high in cycle 1.
  - mem_ack in cycle 1+k (k ≥ 0 wait states) is captured at the end of that cycle.
  - done high in cycle 2+k.
  - Total latency from start to done is 2+k cycles. Captured data is visible in the same cycle as done.
- Illegal access: done one cycle after the start edge (cycle 1). mem_req never rises.
- Timeout: done in cycle TIMEOUT+1. If mem_ack arrives in the same cycle the counter hits TIMEOUT, the ack wins and fault=00.
- Back-to-back: a new start is accepted in the first IDLE cycle after DONE. Minimum access period is 3 cycles.

## Structure
- riscv_pkg holds:
  - funct3 load/store encodings (LB, LH, LW, LBU, LHU, SB, SH, SW)
  - fault codes
  - the mem_unit state encoding
- Sub-module load_store_align, purely combinational:
  - Inputs: funct3, addr[1:0], wdata, mem_rdata.
  - Outputs: be, replicated wdata, extended load data, illegal flag.
- mem_unit holds the FSM, wait counter and registers.

## Test plan
- Fetch, pc=0x00000010, ack after 0 wait states, mem_rdata=0x00500093 -> mem_addr=0x10, done at cycle 2, ir=0x00500093, old_pc=0x10, fault=00.
- lb and lbu at alu_result=0x103, mem_rdata=0x80FF_0000 -> lb rdata=0xFFFFFF80; lbu rdata=0x00000080; be=1111.
- sh at 0x102 with wdata=0x1234ABCD -> be=1100, mem_wdata=0xABCDABCD, mem_we=1; rdata and ir unchanged.
- lw at 0x201 -> no mem_req, done at cycle 1, fault=01. Same result for a fetch at pc=0x6.
- TIMEOUT=4, no ack -> mem_req high for cycles 1-4, done at cycle 5, fault=10. Repeat with ack in cycle 4 -> fault=00.
- Assert rst in the second wait cycle of a store -> mem_req=0 immediately, all outputs at reset values. A late ack is ignored. The next start completes normally.
